// File: rtl/fbcv_fib_seq_engine.sv
// fbcv_fib_seq_engine: multi-cycle Fibonacci engine, F(0)=F(1)=1.
// Loads a=b=1 and cnt=N on start, then adds once per cycle until F(N) sits in b.
// Optional feature macro: FBCV_SATURATE_EN (sum clamps to all-ones on carry).
// Default build (macro undefined): sum wraps modulo 2^DATA_W, overflow flag only.
module fbcv_fib_seq_engine #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned N_W    = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [N_W-1:0]    n_in,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] result,
    output logic              overflow
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]        r_state, w_state_d;
    logic [DATA_W-1:0] r_a, w_a_d;
    logic [DATA_W-1:0] r_b, w_b_d;
    logic [N_W-1:0]    r_cnt, w_cnt_d;
    logic [DATA_W-1:0] r_result, w_result_d;
    logic              r_overflow, w_overflow_d;

    logic [DATA_W:0]   w_sum;
    logic              w_carry;
    logic [DATA_W-1:0] w_b_step;
    logic              w_n_small;

    assign w_sum     = {1'b0, r_a} + {1'b0, r_b};
    assign w_carry   = w_sum[DATA_W];
    // Indices 0 and 1 need no iteration: F is already 1.
    assign w_n_small = (n_in[N_W-1:1] == '0);

`ifdef FBCV_SATURATE_EN
    // Once b is all-ones every later add carries too, so b stays pinned.
    assign w_b_step = w_carry ? {DATA_W{1'b1}} : w_sum[DATA_W-1:0];
`else
    assign w_b_step = w_sum[DATA_W-1:0];
`endif

    // Next-state and datapath update for the IDLE/CALC/DONE sequence.
    always_comb begin
        w_state_d    = r_state;
        w_a_d        = r_a;
        w_b_d        = r_b;
        w_cnt_d      = r_cnt;
        w_result_d   = r_result;
        w_overflow_d = r_overflow;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    w_a_d        = DATA_W'(1);
                    w_b_d        = DATA_W'(1);
                    w_cnt_d      = n_in;
                    w_overflow_d = 1'b0;
                    if (w_n_small) begin
                        w_state_d  = S_DONE;
                        w_result_d = DATA_W'(1);
                    end else begin
                        w_state_d  = S_CALC;
                    end
                end else begin
                    w_state_d = S_IDLE;
                end
            end
            S_CALC: begin
                if (abort) begin
                    // Drop the operation; result keeps the last completed value.
                    w_state_d = S_IDLE;
                end else begin
                    w_a_d        = r_b;
                    w_b_d        = w_b_step;
                    w_cnt_d      = r_cnt - N_W'(1);
                    w_overflow_d = r_overflow | w_carry;
                    // Exiting at cnt==2 means cnt never needs to go below 2.
                    if (r_cnt == N_W'(2)) begin
                        w_state_d  = S_DONE;
                        w_result_d = w_b_step;
                    end
                end
            end
            default: begin
                w_state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with asynchronous active-high reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_a        <= '0;
            r_b        <= '0;
            r_cnt      <= '0;
            r_result   <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_state    <= w_state_d;
            r_a        <= w_a_d;
            r_b        <= w_b_d;
            r_cnt      <= w_cnt_d;
            r_result   <= w_result_d;
            r_overflow <= w_overflow_d;
        end
    end

    assign busy     = (r_state == S_CALC);
    assign done     = (r_state == S_DONE);
    assign result   = r_result;
    assign overflow = r_overflow;

endmodule

// File: tb/tb_fbcv_fib_seq_engine.sv
// Self-checking bench for fbcv_fib_seq_engine: directed scenarios plus random
// indices checked against an iterative Fibonacci reference model.
module tb_fbcv_fib_seq_engine;

    localparam int DATA_W = 16;
    localparam int N_W    = 12;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic              abort;
    logic [N_W-1:0]    n_in;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] result;
    logic              overflow;

    int checks = 0;
    int errors = 0;

    fbcv_fib_seq_engine #(
        .DATA_W (DATA_W),
        .N_W    (N_W)
    ) u_dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .abort    (abort),
        .n_in     (n_in),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // F(0)=F(1)=1; each sum beyond DATA_W bits flags overflow and wraps or clamps.
    function automatic void ref_fib(input int n, output int res, output bit ov);
        longint fa = 1;
        longint fb = 1;
        longint s;
        longint lim = longint'(1) << DATA_W;
        ov = 1'b0;
        for (int k = 2; k <= n; k++) begin
            s = fa + fb;
            if (s >= lim) begin
                ov = 1'b1;
`ifdef FBCV_SATURATE_EN
                s = lim - 1;
`else
                s = s - lim;
`endif
            end
            fa = fb;
            fb = s;
        end
        res = int'(fb);
    endfunction

    // Called in the cycle after the accepting edge; returns in the done cycle.
    task automatic wait_done(input int n, input bit noise, input int exp_res, input bit exp_ov);
        int lat = 1;
        int busy_cyc = 0;
        bit seen = 1'b0;
        int exp_lat = (n < 2) ? 1 : n;
        chk("ov_clear_on_start", 32'(overflow), 32'd0);
        while (!seen && lat <= exp_lat + 4) begin
            chk("busy_done_excl", 32'(busy & done), 32'd0);
            if (done) begin
                seen = 1'b1;
            end else begin
                if (busy) busy_cyc++;
                if (noise) begin
                    start = 1'($urandom_range(0, 1));
                    n_in  = N_W'($urandom);
                end
                @(posedge clk);
                #1;
                lat++;
            end
        end
        start = 1'b0;
        chk("done_seen", 32'(seen), 32'd1);
        if (seen) begin
            chk("latency", 32'(lat), 32'(exp_lat));
            chk("busy_cycles", 32'(busy_cyc), 32'(exp_lat - 1));
            chk("result", 32'(result), 32'(exp_res));
            chk("overflow", 32'(overflow), 32'(exp_ov));
        end
    endtask

    task automatic run_op(input int n, input bit noise, input int exp_res, input bit exp_ov);
        @(negedge clk);
        start = 1'b1;
        n_in  = N_W'(n);
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(n, noise, exp_res, exp_ov);
        @(posedge clk);
        #1;
        chk("done_one_cycle", 32'(done), 32'd0);
        chk("result_held", 32'(result), 32'(exp_res));
    endtask

    task automatic run_ref(input int n, input bit noise);
        int  r;
        bit  o;
        ref_fib(n, r, o);
        run_op(n, noise, r, o);
    endtask

    initial begin
        int r;
        bit o;
        int prev;
        reset = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        n_in  = '0;
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_result", 32'(result), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Trivial indices.
        run_op(0, 1'b0, 1, 1'b0);
        run_op(1, 1'b0, 1, 1'b0);
        run_op(2, 1'b0, 2, 1'b0);
        run_op(10, 1'b0, 89, 1'b0);

        // Width boundary.
        run_op(23, 1'b0, 46368, 1'b0);
`ifdef FBCV_SATURATE_EN
        run_op(24, 1'b0, 32'hFFFF, 1'b1);
`else
        run_op(24, 1'b0, 9489, 1'b1);
`endif

        // Start ignored mid-CALC, then abort: no done, result unchanged.
        prev = int'(result);
        @(negedge clk);
        start = 1'b1;
        n_in  = N_W'(10);
        @(posedge clk); #1; start = 1'b0;
        @(posedge clk); #1;
        start = 1'b1;
        n_in  = N_W'(3);
        @(posedge clk); #1; start = 1'b0;
        chk("ignored_start_busy", 32'(busy), 32'd1);
        @(posedge clk); #1;
        abort = 1'b1;
        @(posedge clk); #1; abort = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_result", 32'(result), 32'(prev));
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            chk("abort_no_done", 32'(done | busy), 32'd0);
        end

        // Abort while idle has no effect on an accepted start.
        @(negedge clk);
        start = 1'b1;
        abort = 1'b1;
        n_in  = N_W'(3);
        @(posedge clk); #1;
        start = 1'b0;
        abort = 1'b0;
        wait_done(3, 1'b0, 3, 1'b0);

        // Back-to-back: overflowing op, then N=5, then N=6 started in DONE.
        run_op(24, 1'b0, (`ifdef FBCV_SATURATE_EN 32'hFFFF `else 9489 `endif), 1'b1);
        @(negedge clk);
        start = 1'b1;
        n_in  = N_W'(5);
        @(posedge clk); #1; start = 1'b0;
        wait_done(5, 1'b0, 8, 1'b0);
        start = 1'b1;
        n_in  = N_W'(6);
        @(posedge clk); #1; start = 1'b0;
        chk("b2b_accept_busy", 32'(busy), 32'd1);
        wait_done(6, 1'b0, 13, 1'b0);
        start = 1'b1;
        n_in  = N_W'(30);
        @(posedge clk); #1; start = 1'b0;
        ref_fib(30, r, o);
        wait_done(30, 1'b0, r, o);
        @(posedge clk); #1;

        // Largest legal index.
        run_ref((1 << N_W) - 1, 1'b0);

        // Randomized indices with start noise during CALC.
        for (int i = 0; i < 24; i++) begin
            if ($urandom_range(0, 5) == 0) run_ref(int'($urandom_range(0, (1 << N_W) - 1)), 1'b1);
            else run_ref(int'($urandom_range(0, 40)), 1'($urandom_range(0, 1)));
        end

        // Asynchronous reset mid-CALC clears everything in the same cycle.
        @(negedge clk);
        start = 1'b1;
        n_in  = N_W'(20);
        @(posedge clk); #1; start = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_done", 32'(done), 32'd0);
        chk("arst_result", 32'(result), 32'd0);
        chk("arst_overflow", 32'(overflow), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        run_op(7, 1'b0, 21, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
